// File: rtl/moore_seq_pkg.sv
// Shared definitions for the moore_seq step sequencer family.
// Holds the state-count ceiling, the per-edge action encoding and a width helper.
// Pure declarations; no logic, no latency, no flow control.
package moore_seq_pkg;

  // Largest supported number of sequencer states.
  localparam int MOORE_SEQ_MAX_ST = 16;

  // What the sequencer does on a given rising edge, in priority order.
  typedef enum logic [1:0] {
    ACT_CLR   = 2'd0,  // synchronous return to state 0
    ACT_HOLD  = 2'd1,  // en low: state and dwell counter frozen
    ACT_DWELL = 2'd2,  // still dwelling: count up
    ACT_STEP  = 2'd3   // dwell expired: move to the next unskipped state
  } act_e;

  // Ceiling log2 for state-width derivation; bounded loop so it elaborates
  // cleanly in any toolflow. Returns at least 1 for n >= 2.
  function automatic int moore_seq_clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < n) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/moore_seq_next.sv
// Next-state search: lowest index above state whose skip bit is clear, else 0.
// Purely combinational, zero cycles.
// No flow control; output follows inputs continuously.
module moore_seq_next
  import moore_seq_pkg::*;
#(
  parameter int NUM_ST = 4,
  parameter int ST_W   = moore_seq_clog2(NUM_ST)
) (
  input  logic [ST_W-1:0]   state,
  input  logic [NUM_ST-1:0] skip_mask,
  output logic [ST_W-1:0]   nxt
);

  // Never search past the supported ceiling, whatever NUM_ST is set to.
  localparam int SEARCH_N = (NUM_ST < MOORE_SEQ_MAX_ST) ? NUM_ST : MOORE_SEQ_MAX_ST;

  // State 0 can never be skipped, so its mask bit plays no part in the search.
  logic unused_skip0;
  assign unused_skip0 = skip_mask[0];

  // Masked priority search; scanning downward lets the lowest hit win.
  // An out-of-range state finds no candidate above it and falls back to 0.
  always_comb begin
    nxt = '0;
    for (int j = SEARCH_N - 1; j >= 1; j--) begin
      if ((ST_W'(j) > state) && !skip_mask[j]) begin
        nxt = ST_W'(j);
      end
    end
  end

endmodule

// File: rtl/moore_seq.sv
// Parametrised Moore step sequencer with run-time skip mask and per-state dwell.
// state updates on the edge; out mirrors state one cycle later; wrap aligns with state.
// No backpressure: en=0 freezes state and dwell count, clr forces state 0.
module moore_seq
  import moore_seq_pkg::*;
#(
  parameter int NUM_ST  = 4,                         // legal range 2..16
  parameter int ST_W    = moore_seq_clog2(NUM_ST),   // derived, leave at default
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active low
  input  logic               en,
  input  logic               clr,
  input  logic [NUM_ST-1:0]  skip_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [ST_W-1:0]    state,
  output logic [ST_W-1:0]    out,
  output logic               wrap
);

  logic [ST_W-1:0]    nxt;
  logic [ST_W-1:0]    state_d;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_d;
  logic               wrap_d;
  act_e               act;

  moore_seq_next #(
    .NUM_ST (NUM_ST),
    .ST_W   (ST_W)
  ) u_next (
    .state     (state),
    .skip_mask (skip_mask),
    .nxt       (nxt)
  );

  // Pick this edge's action; clr outranks en, and >= lets a lowered dwell
  // release the current state on the very next enabled edge.
  always_comb begin
    act = ACT_HOLD;
    if (clr) begin
      act = ACT_CLR;
    end else if (!en) begin
      act = ACT_HOLD;
    end else if (cnt < dwell) begin
      act = ACT_DWELL;
    end else begin
      act = ACT_STEP;
    end
  end

  // Next values for state, dwell counter and wrap pulse.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wrap_d  = 1'b0;
    case (act)
      ACT_CLR: begin
        state_d = '0;
        cnt_d   = '0;
      end
      ACT_HOLD: begin
        state_d = state;
        cnt_d   = cnt;
      end
      ACT_DWELL: begin
        cnt_d = cnt + DWELL_W'(1);
      end
      ACT_STEP: begin
        state_d = nxt;
        cnt_d   = '0;
        wrap_d  = (nxt == '0);
      end
      default: begin
        state_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state, dwell counter and wrap pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      wrap  <= wrap_d;
    end
  end

  // Moore output: registered copy of state, updated on every edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else begin
      out <= state;
    end
  end

endmodule

// File: tb/tb_moore_seq.sv
module tb_moore_seq;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [3:0] skip_mask;
  logic [3:0] dwell;
  logic [1:0] state;
  logic [1:0] out;
  logic       wrap;

  logic       en5;
  logic       clr5;
  logic [4:0] skip5;
  logic [2:0] dwell5;
  logic [2:0] state5;
  logic [2:0] out5;
  logic       wrap5;

  int applied;
  int miscompares;

  moore_seq #(.NUM_ST(4), .DWELL_W(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .skip_mask (skip_mask),
    .dwell     (dwell),
    .state     (state),
    .out       (out),
    .wrap      (wrap)
  );

  moore_seq #(.NUM_ST(5), .DWELL_W(3)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .en        (en5),
    .clr       (clr5),
    .skip_mask (skip5),
    .dwell     (dwell5),
    .state     (state5),
    .out       (out5),
    .wrap      (wrap5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [3:0] mask;
    logic [3:0] dw;
    logic [1:0] st;
    logic [1:0] o;
    logic       w;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic e, input logic c, input logic [3:0] m,
                             input logic [3:0] d, input logic [1:0] s,
                             input logic [1:0] o, input logic w);
    vec_t r;
    r.en = e; r.clr = c; r.mask = m; r.dw = d; r.st = s; r.o = o; r.w = w;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge, then settle 1 time unit before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int max5;
    int wraps5;
    int first_wrap;
    int second_wrap;

    applied     = 0;
    miscompares = 0;
    rst = 1'b0; en = 1'b0; clr = 1'b0; skip_mask = 4'b0; dwell = 4'd0;
    en5 = 1'b0; clr5 = 1'b0; skip5 = 5'b0; dwell5 = 3'd0;

    // Basic run, dwell=0, no skips
    tbl.push_back(v(1, 0, 4'b0000, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 4'b0000, 0, 2, 1, 0));
    tbl.push_back(v(1, 0, 4'b0000, 0, 3, 2, 0));
    tbl.push_back(v(1, 0, 4'b0000, 0, 0, 3, 1));
    tbl.push_back(v(1, 0, 4'b0000, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 4'b0000, 0, 2, 1, 0));
    tbl.push_back(v(1, 0, 4'b0000, 0, 3, 2, 0));
    tbl.push_back(v(1, 0, 4'b0000, 0, 0, 3, 1));
    // Bypass state 2
    tbl.push_back(v(1, 0, 4'b0100, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 4'b0100, 0, 3, 1, 0));
    tbl.push_back(v(1, 0, 4'b0100, 0, 0, 3, 1));
    tbl.push_back(v(1, 0, 4'b0100, 0, 1, 0, 0));
    // Everything above 0 skipped: 1 -> 0 -> 0 -> 0, wrap each time
    tbl.push_back(v(1, 0, 4'b1110, 0, 0, 1, 1));
    tbl.push_back(v(1, 0, 4'b1110, 0, 0, 0, 1));
    tbl.push_back(v(1, 0, 4'b1110, 0, 0, 0, 1));
    // Dwell 2: three cycles per state
    tbl.push_back(v(1, 0, 4'b0000, 2, 0, 0, 0));
    tbl.push_back(v(1, 0, 4'b0000, 2, 0, 0, 0));
    tbl.push_back(v(1, 0, 4'b0000, 2, 1, 0, 0));
    tbl.push_back(v(1, 0, 4'b0000, 2, 1, 1, 0));
    tbl.push_back(v(1, 0, 4'b0000, 2, 1, 1, 0));
    tbl.push_back(v(1, 0, 4'b0000, 2, 2, 1, 0));
    tbl.push_back(v(1, 0, 4'b0000, 2, 2, 2, 0));
    tbl.push_back(v(1, 0, 4'b0000, 2, 2, 2, 0));
    // dwell lowered to 0 with cnt=2: leave immediately
    tbl.push_back(v(1, 0, 4'b0000, 0, 3, 2, 0));
    tbl.push_back(v(1, 0, 4'b0000, 0, 0, 3, 1));
    tbl.push_back(v(1, 0, 4'b0000, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 4'b0000, 0, 2, 1, 0));
    // State 2, dwell 2: cnt->1, freeze 5 cycles, then cnt->2, then step
    tbl.push_back(v(1, 0, 4'b0000, 2, 2, 2, 0));
    tbl.push_back(v(0, 0, 4'b0000, 2, 2, 2, 0));
    tbl.push_back(v(0, 0, 4'b0000, 2, 2, 2, 0));
    tbl.push_back(v(0, 0, 4'b0000, 2, 2, 2, 0));
    tbl.push_back(v(0, 0, 4'b0000, 2, 2, 2, 0));
    tbl.push_back(v(0, 0, 4'b0000, 2, 2, 2, 0));
    tbl.push_back(v(1, 0, 4'b0000, 2, 2, 2, 0));
    tbl.push_back(v(1, 0, 4'b0000, 2, 3, 2, 0));
    // clr with en in state 3: back to 0 without wrap
    tbl.push_back(v(1, 1, 4'b0000, 0, 0, 3, 0));
    tbl.push_back(v(1, 0, 4'b0000, 0, 1, 0, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_out", int'(out), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_state5", int'(state5), 0);
    #3 rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; clr = tbl[i].clr; skip_mask = tbl[i].mask; dwell = tbl[i].dw;
      step();
      check($sformatf("v%0d_state", i), int'(state), int'(tbl[i].st));
      check($sformatf("v%0d_out", i), int'(out), int'(tbl[i].o));
      check($sformatf("v%0d_wrap", i), int'(wrap), int'(tbl[i].w));
    end

    // Async reset between edges while wrap and out are non-zero
    en = 1'b1; clr = 1'b0; skip_mask = 4'b1110; dwell = 4'd0;
    step();
    check("pre_rst_wrap", int'(wrap), 1);
    check("pre_rst_out", int'(out), 1);
    #3 rst = 1'b0;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_out", int'(out), 0);
    check("arst_wrap", int'(wrap), 0);
    #1 rst = 1'b1;
    skip_mask = 4'b0000; dwell = 4'd2;
    step();
    check("rel1_state", int'(state), 0);
    step();
    check("rel2_state", int'(state), 0);
    step();
    check("rel3_state", int'(state), 1);
    check("rel3_out", int'(out), 0);
    check("rel3_wrap", int'(wrap), 0);
    step();
    check("rel4_out", int'(out), 1);

    // NUM_ST=5, dwell=7: 40-cycle period, states 5..7 never seen
    en = 1'b0;
    en5 = 1'b1; dwell5 = 3'd7; skip5 = 5'b0;
    max5 = 0; wraps5 = 0; first_wrap = 0; second_wrap = 0;
    for (int i = 1; i <= 80; i++) begin
      step();
      if (int'(state5) > max5) max5 = int'(state5);
      if (wrap5) begin
        wraps5++;
        if (first_wrap == 0) first_wrap = i;
        else if (second_wrap == 0) second_wrap = i;
      end
    end
    check("sweep_max_state", max5, 4);
    check("sweep_wraps", wraps5, 2);
    check("sweep_first_wrap", first_wrap, 40);
    check("sweep_period", second_wrap - first_wrap, 40);
    check("sweep_end_state", int'(state5), 0);

    // NUM_ST=5 with 2 and 3 skipped: 0 -> 1 -> 4 -> 0
    dwell5 = 3'd0; skip5 = 5'b01100;
    step();
    check("n5_skip_s1", int'(state5), 1);
    step();
    check("n5_skip_s4", int'(state5), 4);
    step();
    check("n5_skip_s0", int'(state5), 0);
    check("n5_skip_wrap", int'(wrap5), 1);
    check("n5_skip_out", int'(out5), 4);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/moore_seq.md
# moore_seq

Parametrised Moore-type state sequencer: the next generation of the team's fixed 4-state bypassable sequencer. It steps through `NUM_ST` states in ascending order. Any subset of states except state 0 can be skipped at run time, and each state can be held for a programmable dwell time. The current state index is presented on a registered output one cycle behind the state register. It sits in control paths as a phase/step generator (mux selects, pipeline phase strobes) and can replace the fixed 4-state version directly: with `NUM_ST=4`, `DWELL_W` of any value, `dwell=0`, `en=1` and `skip_mask=4'b0100`, it reproduces the original bypass behaviour.

## Interface
Parameters:
- `NUM_ST`, default 4: number of states, legal range 2..16.
- `ST_W`, default `$clog2(NUM_ST)`: state/output width; derived, not to be overridden.
- `DWELL_W`, default 4: width of the dwell count.

Ports (single clock; reset is asynchronous and active-low):
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous active-low reset.
- `en`  in  1: advance enable; 0 freezes the state and dwell counter.
- `clr`  in  1: synchronous return to state 0.
- `skip_mask`  in  NUM_ST: bit j=1 skips state j; bit 0 is ignored.
- `dwell`  in  DWELL_W: each visited state lasts dwell+1 enabled cycles.
- `state`  out  ST_W: current state register.
- `out`  out  ST_W: registered copy of `state`, one cycle later.
- `wrap`  out  1: one-cycle pulse marking the return to state 0.

## Operation
- Reset (`rst`=0, asynchronous): `state`=0, dwell counter `cnt`=0, `out`=0, `wrap`=0.
- Each rising edge is evaluated in priority order:
  1. `clr`=1: `state`←0, `cnt`←0, `wrap`←0. `clr` overrides `en`.
  2. `en`=0: `state` and `cnt` hold; `wrap`←0.
  3. `en`=1 and `cnt` < `dwell`: `cnt`←`cnt`+1; `wrap`←0.
  4. `en`=1 and `cnt` ≥ `dwell`: `state`←`nxt`; `cnt`←0; `wrap`←(`nxt`==0).
- `nxt` is the lowest index j > `state` with `skip_mask[j]`=0. If no such j exists, `nxt`=0.
- State 0 is never skipped.
- If every bit 1..NUM_ST-1 is set, the sequencer goes 0→0. Each such transition still pulses `wrap`.
- `skip_mask` and `dwell` are sampled live; there is no shadowing.
  - A mask change takes effect at the next transition.
  - If `dwell` is lowered below the current `cnt`, the comparison uses ≥, so the sequencer transitions on the next enabled edge.
- `cnt` is DWELL_W bits wide and never exceeds `dwell`, so it cannot overflow.
- `out` ← `state` on every edge, regardless of `en` and `clr`. It is the Moore output: a pure function of the registered state, delayed one cycle.
- `state` must never hold a value ≥ NUM_ST (relevant when NUM_ST is not a power of 2). An illegal value, however reached, goes to 0 on the next enabled transition.

## Timing
- Transition-to-`out` latency: `state` updates at edge N; `out` shows the same value from edge N+1.
- `wrap` is high in exactly the same cycle in which `state` first reads 0 after an advance-driven transition. A `clr`-driven return does not pulse `wrap`.
- Period of one full sequence: (number of non-skipped states) × (`dwell`+1) enabled cycles.
- Reset deasserted mid-sequence: all registers restart from 0 on the first edge after release; there are no partial-state artefacts.

## Structure
- Shared package `moore_seq_pkg`:
  - constant `MOORE_SEQ_MAX_ST`=16;
  - a `clog2`-style width function, if the toolflow lacks `$clog2`.
- One combinational sub-module `moore_seq_next`, parameters `NUM_ST`, `ST_W`:
  - inputs `state` and `skip_mask`;
  - output `nxt`;
  - implemented as a masked priority search over indices above `state`, with wrap to 0.
- The top level holds the `state`, `cnt`, `out` and `wrap` registers and the priority logic.

## Test plan
- Basic run: `NUM_ST`=4, `dwell`=0, `skip_mask`=0, `en`=1 → `state` 0,1,2,3,0,1…; `out` is the same sequence lagged by 1; `wrap`=1 only in cycles where `state`=0 after 3.
- Bypass: `skip_mask`=4'b0100 → `state` 0,1,3,0. Then `skip_mask`=4'b1110 → `state` 0,0,0 with `wrap`=1 every cycle.
- Dwell: `dwell`=2 → each state held 3 cycles. Lower `dwell` to 0 while `cnt`=2 → transition on the next edge.
- Enable/clear: drop `en` for 5 cycles in state 2 → `state` and `cnt` frozen. Assert `clr`=1 with `en`=1 in state 3 → `state`=0 next edge, `wrap`=0.
- Async reset mid-dwell: pull `rst` low between edges → `state`, `out`, `wrap` go to 0 immediately. After release, the sequence restarts at 0 with a full dwell.
- Parameter sweep: `NUM_ST`=5, `DWELL_W`=3, `dwell`=7 → `state` never reaches 5..7; period = 5×8 = 40 cycles; `wrap` once per period.
